// File: rtl/multicycle_main_controller_pkg.sv
// Shared definitions for the multi-cycle RV32I main controller.
// Provides:
//   - RV32I major opcode values
//   - state_e : controller states (IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP)
//   - cls_e   : instruction classes produced by the opcode classifier
//   - pc_src / wb_sel / alu_op encodings
//   - helpers giving the ALU controls for a given instruction class
package multicycle_main_controller_pkg;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LW    = 7'b0000011;
  localparam logic [6:0] OPC_SW    = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_ILL, CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BR,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC
  } cls_e;

  localparam logic [1:0] PC_SEQ = 2'b00;  // pc + 4
  localparam logic [1:0] PC_REL = 2'b01;  // pc + imm
  localparam logic [1:0] PC_REG = 2'b10;  // rs1 + imm

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  function automatic logic [1:0] alu_op_for(cls_e c);
    case (c)
      CLS_R:   return ALU_R;
      CLS_I:   return ALU_I;
      CLS_BR:  return ALU_BR;
      default: return ALU_ADD;
    endcase
  endfunction

  // Only R-type and branch compare use rs2; everything else adds an immediate.
  function automatic logic alu_src_b_for(cls_e c);
    case (c)
      CLS_R, CLS_BR, CLS_ILL: return 1'b0;
      default:                return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_main_controller_if.sv
// Memory handshake bundle between the controller and the instruction/data
// memory ports.
//   imem_req   : fetch request          (controller -> memory)
//   imem_ready : fetch complete          (memory -> controller)
//   dmem_req   : data access request     (controller -> memory)
//   dmem_we    : 1 = store               (controller -> memory)
//   dmem_ready : data access complete    (memory -> controller)
interface multicycle_main_controller_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (output imem_req, dmem_req, dmem_we,
                  input  imem_ready, dmem_ready);
  modport slave  (input  imem_req, dmem_req, dmem_we,
                  output imem_ready, dmem_ready);
endinterface

// File: rtl/multicycle_main_controller_opcode_classifier.sv
// Combinational opcode classifier.
//   opcode_i : major opcode field
//   cls_o    : instruction class (CLS_ILL when not recognised)
//   legal_o  : 1 when the opcode is a supported instruction
// With EN_UPPER=0, LUI and AUIPC are reported as illegal.
module opcode_classifier
  import multicycle_main_controller_pkg::*;
#(
  parameter int OPC_W    = 7,
  parameter bit EN_UPPER = 1'b1
) (
  input  logic [OPC_W-1:0] opcode_i,
  output cls_e             cls_o,
  output logic             legal_o
);

  always_comb begin
    cls_o = CLS_ILL;
    case (opcode_i)
      OPC_W'(OPC_R):     cls_o = CLS_R;
      OPC_W'(OPC_I):     cls_o = CLS_I;
      OPC_W'(OPC_LW):    cls_o = CLS_LW;
      OPC_W'(OPC_SW):    cls_o = CLS_SW;
      OPC_W'(OPC_BR):    cls_o = CLS_BR;
      OPC_W'(OPC_JAL):   cls_o = CLS_JAL;
      OPC_W'(OPC_JALR):  cls_o = CLS_JALR;
      OPC_W'(OPC_LUI):   cls_o = EN_UPPER ? CLS_LUI   : CLS_ILL;
      OPC_W'(OPC_AUIPC): cls_o = EN_UPPER ? CLS_AUIPC : CLS_ILL;
      default:           cls_o = CLS_ILL;
    endcase
  end

  assign legal_o = (cls_o != CLS_ILL);

endmodule

// File: rtl/multicycle_main_controller.sv
// Multi-cycle RV32I main controller.
// Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives the PC, IR,
// register file, ALU and memory handshake controls.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   mem_if          : memory handshake (imem/dmem req, ready, dmem_we)
//   opcode_i        : instr[6:0] from IR, sampled in DECODE only
//   branch_taken_i  : ALU compare result, used in EXEC of a branch
//   ir_we_o, pc_we_o, pc_src_o, reg_write_o, alu_src_b_o, wb_sel_o, alu_op_o
//                   : datapath controls
//   illegal_o       : sticky illegal-opcode trap flag
//   timeout_o       : sticky memory-handshake timeout flag
//   state_dbg_o     : current state encoding
// Outputs depend only on the registered state/class plus branch_taken_i and
// the ready inputs, so there is no path from opcode_i to any output.
module multicycle_main_controller
  import multicycle_main_controller_pkg::*;
#(
  parameter int OPC_W       = 7,
  parameter int MEM_TIMEOUT = 16,
  parameter bit EN_UPPER    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  multicycle_main_controller_if.master mem_if,
  input  logic [OPC_W-1:0]             opcode_i,
  input  logic                         branch_taken_i,
  output logic                         ir_we_o,
  output logic                         pc_we_o,
  output logic [1:0]                   pc_src_o,
  output logic                         reg_write_o,
  output logic                         alu_src_b_o,
  output logic [1:0]                   wb_sel_o,
  output logic [1:0]                   alu_op_o,
  output logic                         illegal_o,
  output logic                         timeout_o,
  output logic [2:0]                   state_dbg_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q;
  cls_e             opc_cls_q;   // latched opcode, held in classified form
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             illegal_q;
  logic             timeout_q;
  logic             wait_expired;

  cls_e dec_cls;
  logic dec_legal;

  opcode_classifier #(
    .OPC_W    (OPC_W),
    .EN_UPPER (EN_UPPER)
  ) u_classifier (
    .opcode_i (opcode_i),
    .cls_o    (dec_cls),
    .legal_o  (dec_legal)
  );

  assign cnt_d = cnt_q + 1'b1;
  // This cycle is the MEM_TIMEOUT-th consecutive wait; a ready in the same
  // cycle is checked first and takes priority.
  assign wait_expired = (cnt_d == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      opc_cls_q <= CLS_ILL;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // Counter clears on every transition; only wait cycles override this.
      cnt_q <= '0;
      case (state_q)
        ST_IDLE: state_q <= ST_FETCH;
        ST_FETCH: begin
          if (mem_if.imem_ready) begin
            state_q <= ST_DECODE;
          end else if (wait_expired) begin
            state_q   <= ST_TRAP;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DECODE: begin
          opc_cls_q <= dec_cls;
          if (dec_legal) begin
            state_q <= ST_EXEC;
          end else begin
            state_q   <= ST_TRAP;
            illegal_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          case (opc_cls_q)
            CLS_LW, CLS_SW: state_q <= ST_MEM;
            CLS_BR:         state_q <= ST_FETCH;
            default:        state_q <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_if.dmem_ready) begin
            state_q <= (opc_cls_q == CLS_LW) ? ST_WB : ST_FETCH;
          end else if (wait_expired) begin
            state_q   <= ST_TRAP;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_WB:   state_q <= ST_FETCH;
        ST_TRAP: state_q <= ST_TRAP;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic imem_req_c;
  logic dmem_req_c;
  logic dmem_we_c;

  always_comb begin
    imem_req_c  = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_src_o    = PC_SEQ;
    reg_write_o = 1'b0;
    alu_src_b_o = 1'b0;
    wb_sel_o    = WB_ALU;
    alu_op_o    = ALU_ADD;
    case (state_q)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        ir_we_o    = mem_if.imem_ready;
      end
      ST_EXEC: begin
        alu_op_o    = alu_op_for(opc_cls_q);
        alu_src_b_o = alu_src_b_for(opc_cls_q);
        if (opc_cls_q == CLS_BR) begin
          pc_we_o  = 1'b1;
          pc_src_o = branch_taken_i ? PC_REL : PC_SEQ;
        end
      end
      ST_MEM: begin
        dmem_req_c  = 1'b1;
        dmem_we_c   = (opc_cls_q == CLS_SW);
        alu_op_o    = ALU_ADD;
        alu_src_b_o = 1'b1;
        // A store retires here, so this is its single PC update.
        if (mem_if.dmem_ready && opc_cls_q == CLS_SW) begin
          pc_we_o = 1'b1;
        end
      end
      ST_WB: begin
        alu_op_o    = alu_op_for(opc_cls_q);
        alu_src_b_o = alu_src_b_for(opc_cls_q);
        reg_write_o = 1'b1;
        pc_we_o     = 1'b1;
        case (opc_cls_q)
          CLS_LW:   wb_sel_o = WB_MEM;
          CLS_JAL:  begin pc_src_o = PC_REL; wb_sel_o = WB_PC4; end
          CLS_JALR: begin pc_src_o = PC_REG; wb_sel_o = WB_PC4; end
          CLS_LUI:  wb_sel_o = WB_IMM;
          default:  wb_sel_o = WB_ALU;
        endcase
      end
      default: ;
    endcase
  end

  assign mem_if.imem_req = imem_req_c;
  assign mem_if.dmem_req = dmem_req_c;
  assign mem_if.dmem_we  = dmem_we_c;
  assign illegal_o       = illegal_q;
  assign timeout_o       = timeout_q;
  assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Self-checking bench for multicycle_main_controller. A per-instruction
// cycle trace is derived from the instruction's class and its memory wait
// counts, then played against the DUT one cycle at a time.
module tb_multicycle_main_controller;

  localparam int TO = 16;
  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3,
                 S_MEM = 4, S_WB = 5, S_TRAP = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       imem_ready, dmem_ready, branch_taken;
  logic [6:0] opcode;

  always #5 clk = ~clk;

  multicycle_main_controller_if mif0 ();
  multicycle_main_controller_if mif1 ();
  assign mif0.imem_ready = imem_ready;
  assign mif0.dmem_ready = dmem_ready;
  assign mif1.imem_ready = imem_ready;
  assign mif1.dmem_ready = dmem_ready;

  logic       ir_we0, pc_we0, reg_write0, alu_src_b0, illegal0, timeout0;
  logic [1:0] pc_src0, wb_sel0, alu_op0;
  logic [2:0] state0;
  logic       ir_we1, pc_we1, reg_write1, alu_src_b1, illegal1, timeout1;
  logic [1:0] pc_src1, wb_sel1, alu_op1;
  logic [2:0] state1;

  multicycle_main_controller #(.OPC_W(7), .MEM_TIMEOUT(TO), .EN_UPPER(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_if(mif0), .opcode_i(opcode),
    .branch_taken_i(branch_taken), .ir_we_o(ir_we0), .pc_we_o(pc_we0),
    .pc_src_o(pc_src0), .reg_write_o(reg_write0), .alu_src_b_o(alu_src_b0),
    .wb_sel_o(wb_sel0), .alu_op_o(alu_op0), .illegal_o(illegal0),
    .timeout_o(timeout0), .state_dbg_o(state0));

  multicycle_main_controller #(.OPC_W(7), .MEM_TIMEOUT(TO), .EN_UPPER(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_if(mif1), .opcode_i(opcode),
    .branch_taken_i(branch_taken), .ir_we_o(ir_we1), .pc_we_o(pc_we1),
    .pc_src_o(pc_src1), .reg_write_o(reg_write1), .alu_src_b_o(alu_src_b1),
    .wb_sel_o(wb_sel1), .alu_op_o(alu_op1), .illegal_o(illegal1),
    .timeout_o(timeout1), .state_dbg_o(state1));

  wire [17:0] obs0 = {state0, mif0.imem_req, mif0.dmem_req, mif0.dmem_we, ir_we0,
                      pc_we0, pc_src0, reg_write0, alu_src_b0, wb_sel0, alu_op0,
                      illegal0, timeout0};
  wire [17:0] obs1 = {state1, mif1.imem_req, mif1.dmem_req, mif1.dmem_we, ir_we1,
                      pc_we1, pc_src1, reg_write1, alu_src_b1, wb_sel1, alu_op1,
                      illegal1, timeout1};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One expected cycle: which inputs are pinned (f*) and to what, plus outputs.
  typedef struct {
    bit         fi; bit ir;
    bit         fd; bit dr;
    bit         ft; bit bt;
    bit         fo; logic [6:0] op;
    logic [17:0] exp;
  } cyc_t;
  cyc_t tq[$];

  function automatic logic [17:0] mk(int st, bit ireq, bit dreq, bit dwe, bit irwe,
                                     bit pcwe, int pcs, bit rw, bit sb, int wbs,
                                     int aop, bit ill, bit to);
    return {3'(st), ireq, dreq, dwe, irwe, pcwe, 2'(pcs), rw, sb, 2'(wbs), 2'(aop), ill, to};
  endfunction

  function automatic void push(bit fi, bit ir, bit fd, bit dr, bit ft, bit bt,
                               bit fo, logic [6:0] op, logic [17:0] e);
    cyc_t c;
    c.fi = fi; c.ir = ir; c.fd = fd; c.dr = dr; c.ft = ft; c.bt = bt;
    c.fo = fo; c.op = op; c.exp = e;
    tq.push_back(c);
  endfunction

  function automatic void push_free(logic [17:0] e);
    push(0, 0, 0, 0, 0, 0, 0, 7'd0, e);
  endfunction

  function automatic void push_trap(bit ill, bit to);
    for (int k = 0; k < 3; k++) push_free(mk(S_TRAP, 0,0,0,0,0,0,0,0,0,0, ill, to));
  endfunction

  // 0 illegal, 1 R, 2 I, 3 LW, 4 SW, 5 BR, 6 JAL, 7 JALR, 8 LUI, 9 AUIPC
  function automatic int kind_of(logic [6:0] op, bit upper);
    case (op)
      7'b0110011: return 1;
      7'b0010011: return 2;
      7'b0000011: return 3;
      7'b0100011: return 4;
      7'b1100011: return 5;
      7'b1101111: return 6;
      7'b1100111: return 7;
      7'b0110111: return upper ? 8 : 0;
      7'b0010111: return upper ? 9 : 0;
      default:    return 0;
    endcase
  endfunction

  // Appends one instruction's cycles (from FETCH on); returns 1 if it traps.
  function automatic bit build(logic [6:0] op, int iw, int dw, bit bt);
    int k    = kind_of(op, 1'b1);
    int aop  = (k == 1) ? 2 : (k == 2) ? 3 : (k == 5) ? 1 : 0;
    bit sb   = !(k == 1 || k == 5);
    bit sw   = (k == 4);
    for (int w = 0; w < iw && w < TO; w++)
      push(1, 0, 0, 0, 0, 0, 0, 7'd0, mk(S_FETCH, 1,0,0,0,0,0,0,0,0,0,0,0));
    if (iw >= TO) begin push_trap(0, 1); return 1'b1; end
    push(1, 1, 0, 0, 0, 0, 0, 7'd0, mk(S_FETCH, 1,0,0,1,0,0,0,0,0,0,0,0));
    push(0, 0, 0, 0, 0, 0, 1, op, mk(S_DECODE, 0,0,0,0,0,0,0,0,0,0,0,0));
    if (k == 0) begin push_trap(1, 0); return 1'b1; end
    if (k == 5) begin
      push(0, 0, 0, 0, 1, bt, 0, 7'd0, mk(S_EXEC, 0,0,0,0,1, bt ? 1 : 0, 0, sb, 0, aop, 0,0));
      return 1'b0;
    end
    push_free(mk(S_EXEC, 0,0,0,0,0,0,0, sb, 0, aop, 0,0));
    if (k == 3 || k == 4) begin
      for (int w = 0; w < dw && w < TO; w++)
        push(0, 0, 1, 0, 0, 0, 0, 7'd0, mk(S_MEM, 0,1,sw,0,0,0,0,1,0,0,0,0));
      if (dw >= TO) begin push_trap(0, 1); return 1'b1; end
      push(0, 0, 1, 1, 0, 0, 0, 7'd0, mk(S_MEM, 0,1,sw,0,sw,0,0,1,0,0,0,0));
      if (sw) return 1'b0;
    end
    push_free(mk(S_WB, 0,0,0,0,1, (k == 6) ? 1 : (k == 7) ? 2 : 0, 1, sb,
                 (k == 3) ? 1 : (k == 6 || k == 7) ? 2 : (k == 8) ? 3 : 0, aop, 0,0));
    return 1'b0;
  endfunction

  // Plays the trace; called just after a rising edge, returns just after one.
  task automatic run();
    foreach (tq[i]) begin
      imem_ready   = tq[i].fi ? tq[i].ir : 1'($urandom);
      dmem_ready   = tq[i].fd ? tq[i].dr : 1'($urandom);
      branch_taken = tq[i].ft ? tq[i].bt : 1'($urandom);
      opcode       = tq[i].fo ? tq[i].op : 7'($urandom);
      @(negedge clk);
      check_val($sformatf("cyc%0d_st%0d", cyc_no, tq[i].exp[17:15]),
                {14'd0, obs0}, {14'd0, tq[i].exp});
      cyc_no++;
      @(posedge clk); #1;
    end
    tq.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_val("reset_dut0", {14'd0, obs0}, 32'd0);
    check_val("reset_dut1", {14'd0, obs1}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_free(mk(S_IDLE, 0,0,0,0,0,0,0,0,0,0,0,0));
  endtask

  localparam logic [6:0] LEGAL [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
    7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit trapped;
    logic [6:0] op;
    int iw, dw;
    rst_n = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    branch_taken = 1'b0; opcode = 7'd0;

    // Directed: main instruction flows, including the fetch ready-wins boundary.
    do_reset();
    void'(build(7'b0110011, 0, 0, 0));   // R
    void'(build(7'b0000011, 1, 3, 0));   // LW, MEM lasts 4 cycles
    void'(build(7'b1100011, 0, 0, 1));   // BR taken
    void'(build(7'b1100011, 2, 0, 0));   // BR not taken
    void'(build(7'b1100111, 0, 0, 0));   // JALR
    void'(build(7'b1101111, 0, 0, 0));   // JAL
    void'(build(7'b0100011, 0, 2, 0));   // SW
    void'(build(7'b0010011, TO - 1, 0, 0));
    void'(build(7'b0000011, 0, TO - 1, 0));
    run();

    // Upper-immediate ops: legal on dut0, illegal on the EN_UPPER=0 copy.
    do_reset();
    void'(build(7'b0110111, 0, 0, 0));   // LUI
    void'(build(7'b0010111, 0, 0, 0));   // AUIPC
    run();
    @(negedge clk);
    check_val("no_upper_trap", {14'd0, obs1},
              {14'd0, mk(S_TRAP, 0,0,0,0,0,0,0,0,0,0,1,0)});
    @(posedge clk); #1;

    // Illegal opcode trap.
    do_reset();
    void'(build(7'b1111111, 0, 0, 0));
    run();

    // Fetch timeout and data timeout.
    do_reset();
    void'(build(7'b0110011, TO, 0, 0));
    run();
    do_reset();
    void'(build(7'b0000011, 0, TO, 0));
    run();

    // Reset pulsed in the middle of a data wait.
    do_reset();
    void'(build(7'b0000011, 0, TO, 0));
    while (tq.size() > 6) void'(tq.pop_back());
    run();
    dmem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("rst_in_mem", {14'd0, obs0}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_free(mk(S_IDLE, 0,0,0,0,0,0,0,0,0,0,0,0));
    void'(build(7'b0110011, 0, 0, 0));
    run();

    // Randomized instruction stream.
    do_reset();
    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : LEGAL[$urandom_range(0, 8)];
      iw = ($urandom_range(0, 19) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 3);
      dw = ($urandom_range(0, 19) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 4);
      trapped = build(op, iw, dw, 1'($urandom));
      run();
      if (trapped) begin
        do_reset();
      end
    end
    run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
